// File: rtl/lf_spi_cfg.sv
// lf_spi_cfg: oversampled SPI command receiver for the LF image.
// Everything runs on pck0. spck/mosi/ncs are synchronised, 16-bit frames
// are shifted in MSB first, and a frame is validated and decoded on the
// cycle that ncs is seen to rise.
//
// Ports:
//   pck0        system clock, rising edge
//   rst         synchronous reset, active-high
//   spck, mosi, ncs   raw SPI pins (asynchronous to pck0)
//   conf_word   major mode [7:5] / mode flags [4:0]
//   divisor     clock divider setting
//   user_byte1  edge-detect threshold / user byte
//   cmd_strobe  one-cycle pulse per accepted frame
//   cmd_code    opcode of the last accepted frame
//   frame_err   one-cycle pulse per rejected frame
module lf_spi_cfg #(
  parameter int         SYNC_STAGES = 2,
  parameter int         FRAME_BITS  = 16,
  parameter logic [7:0] DIVISOR_RST = 8'd95,
  parameter logic [7:0] THRESH_RST  = 8'd127
) (
  input  logic       pck0,
  input  logic       rst,
  input  logic       spck,
  input  logic       mosi,
  input  logic       ncs,
  output logic [7:0] conf_word,
  output logic [7:0] divisor,
  output logic [7:0] user_byte1,
  output logic       cmd_strobe,
  output logic [3:0] cmd_code,
  output logic       frame_err
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] ncs_sync, spck_sync, mosi_sync;
  logic                   ncs_d, spck_d;
  // Tracks how many edges since reset; ncs_d only reflects the real pin
  // once the top bit is set, so a low pin held across reset is not
  // mistaken for a falling edge.
  logic [SYNC_STAGES:0]   vld_pipe;

  logic ncs_s, spck_s, mosi_s;
  logic ncs_fall, ncs_rise, spck_rise;

  state_t        state, state_nxt;
  logic [15:0]   shift;
  logic [CW-1:0] cnt;
  logic          close, accept, reject, shift_en, cnt_clr;

  // Synchronisers and edge-detect registers
  always_ff @(posedge pck0) begin
    if (rst) begin
      ncs_sync  <= '1;
      spck_sync <= '0;
      mosi_sync <= '1;
      ncs_d     <= 1'b1;
      spck_d    <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      spck_sync <= {spck_sync[SYNC_STAGES-2:0], spck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ncs_d     <= ncs_s;
      spck_d    <= spck_s;
      vld_pipe  <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign spck_s    = spck_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ncs_fall  = vld_pipe[SYNC_STAGES] & ncs_d & ~ncs_s;
  assign ncs_rise  = ~ncs_d & ncs_s;
  assign spck_rise = spck_s & ~spck_d;

  // State register
  always_ff @(posedge pck0) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ncs_fall) state_nxt = SHIFT;
      SHIFT:   if (ncs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs. Close wins over a coincident spck edge.
  always_comb begin
    close    = (state == SHIFT) && ncs_rise;
    accept   = close && (cnt == CNT_FULL);
    reject   = close && (cnt != CNT_FULL);
    shift_en = (state == SHIFT) && spck_rise && !ncs_rise;
    cnt_clr  = (state == IDLE) && ncs_fall;
  end

  // Datapath and command decode
  always_ff @(posedge pck0) begin
    if (rst) begin
      shift      <= '0;
      cnt        <= '0;
      conf_word  <= 8'h00;
      divisor    <= DIVISOR_RST;
      user_byte1 <= THRESH_RST;
      cmd_code   <= 4'h0;
      cmd_strobe <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cmd_strobe <= accept;
      frame_err  <= reject;
      if (cnt_clr) cnt <= '0;
      if (shift_en) begin
        shift <= {shift[14:0], mosi_s};
        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      end
      if (accept) begin
        cmd_code <= shift[15:12];
        case (shift[15:12])
          4'h1: begin
            conf_word <= shift[7:0];
            // Selecting edge-detect mode restores the default threshold
            if (shift[7:0] == 8'h01) user_byte1 <= THRESH_RST;
          end
          4'h2:    divisor    <= shift[7:0];
          4'h3:    user_byte1 <= shift[7:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lf_spi_cfg.sv
module tb_lf_spi_cfg;
  localparam int SS = 2;

  logic       pck0 = 1'b0;
  logic       rst, spck, mosi, ncs;
  logic [7:0] conf_word, divisor, user_byte1;
  logic       cmd_strobe, frame_err;
  logic [3:0] cmd_code;

  lf_spi_cfg #(.SYNC_STAGES(SS)) dut (
    .pck0(pck0), .rst(rst), .spck(spck), .mosi(mosi), .ncs(ncs),
    .conf_word(conf_word), .divisor(divisor), .user_byte1(user_byte1),
    .cmd_strobe(cmd_strobe), .cmd_code(cmd_code), .frame_err(frame_err)
  );

  always #5 pck0 = ~pck0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nstrobe = 0, nerr = 0, strobe_cyc = 0, rise_cyc = 0;
  bit both_seen = 0;

  always @(posedge pck0) cyc <= cyc + 1;

  always @(negedge pck0) begin
    if (cmd_strobe) begin nstrobe++; strobe_cyc = cyc; end
    if (frame_err) nerr++;
    if (cmd_strobe && frame_err) both_seen = 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  // Reference model: register contents implied by the accepted command list
  logic [7:0] m_conf, m_div, m_ub;
  logic [3:0] m_code;

  task automatic model_reset();
    m_conf = 8'h00; m_div = 8'd95; m_ub = 8'd127; m_code = 4'h0;
  endtask

  task automatic model_frame(input logic [31:0] w, input int nb,
                             output bit es, output bit ee);
    logic [3:0] op;
    logic [7:0] d;
    es = 0; ee = 0;
    if (nb != 16) begin ee = 1; return; end
    es = 1;
    op = w[15:12];
    d  = w[7:0];
    m_code = op;
    if (op == 4'h1) begin m_conf = d; if (d == 8'h01) m_ub = 8'd127; end
    else if (op == 4'h2) m_div = d;
    else if (op == 4'h3) m_ub = d;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge pck0);
    #2;
  endtask

  task automatic send_bits(input logic [31:0] w, input int hi, input int lo, input int ph);
    for (int i = hi; i >= lo; i--) begin
      mosi = w[i]; spck = 1'b0; wait_cyc(ph);
      spck = 1'b1; wait_cyc(ph);
    end
  endtask

  task automatic run_frame(input logic [31:0] w, input int nb, input int ph);
    ncs = 1'b0; wait_cyc(ph);
    if (nb > 0) send_bits(w, nb - 1, 0, ph);
    spck = 1'b0; wait_cyc(ph);
    ncs = 1'b1; rise_cyc = cyc;
    wait_cyc(10);
  endtask

  task automatic check_regs(input string tag, input int s0, input int e0,
                            input bit es, input bit ee);
    chk({tag, ".conf"}, conf_word, m_conf);
    chk({tag, ".div"}, divisor, m_div);
    chk({tag, ".ub"}, user_byte1, m_ub);
    chk({tag, ".code"}, cmd_code, m_code);
    chk({tag, ".strobes"}, nstrobe - s0, es);
    chk({tag, ".errs"}, nerr - e0, ee);
    if (es) chk({tag, ".latency"}, strobe_cyc - rise_cyc, SS + 1);
  endtask

  typedef struct {
    logic [31:0] w;
    int          nb;
    logic [7:0]  conf, div, ub;
    logic [3:0]  code;
    bit          s, e;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int s0, e0;
    bit es, ee;
    tbl[0] = '{32'h2060, 16, 8'h00, 8'h60, 8'h7F, 4'h2, 1, 0};
    tbl[1] = '{32'h3020, 16, 8'h00, 8'h60, 8'h20, 4'h3, 1, 0};
    tbl[2] = '{32'h1001, 16, 8'h01, 8'h60, 8'h7F, 4'h1, 1, 0};
    tbl[3] = '{32'h1021, 16, 8'h21, 8'h60, 8'h7F, 4'h1, 1, 0};
    tbl[4] = '{32'h1008, 15, 8'h21, 8'h60, 8'h7F, 4'h1, 0, 1}; // 0x2011 short
    tbl[5] = '{32'h4022, 17, 8'h21, 8'h60, 8'h7F, 4'h1, 0, 1}; // 0x2011 long
    tbl[6] = '{32'h0000,  0, 8'h21, 8'h60, 8'h7F, 4'h1, 0, 1}; // zero-bit
    tbl[7] = '{32'h5ABC, 16, 8'h21, 8'h60, 8'h7F, 4'h5, 1, 0};

    rst = 1'b1; spck = 1'b0; mosi = 1'b0; ncs = 1'b1;
    model_reset();
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);
    chk("rst.conf", conf_word, 8'h00);
    chk("rst.div", divisor, 8'h5F);
    chk("rst.ub", user_byte1, 8'h7F);
    chk("rst.code", cmd_code, 4'h0);
    chk("rst.strobe", cmd_strobe, 1'b0);
    chk("rst.err", frame_err, 1'b0);
    s0 = nstrobe; e0 = nerr;
    wait_cyc(20);
    chk("idle.strobes", nstrobe - s0, 0);
    chk("idle.errs", nerr - e0, 0);
    chk("idle.div", divisor, 8'h5F);

    // Directed table, spck 8 cycles per phase
    for (int i = 0; i < 8; i++) begin
      s0 = nstrobe; e0 = nerr;
      run_frame(tbl[i].w, tbl[i].nb, 8);
      model_frame(tbl[i].w, tbl[i].nb, es, ee);
      chk($sformatf("tbl%0d.conf", i), conf_word, tbl[i].conf);
      chk($sformatf("tbl%0d.div", i), divisor, tbl[i].div);
      chk($sformatf("tbl%0d.ub", i), user_byte1, tbl[i].ub);
      chk($sformatf("tbl%0d.code", i), cmd_code, tbl[i].code);
      chk($sformatf("tbl%0d.strobes", i), nstrobe - s0, tbl[i].s);
      chk($sformatf("tbl%0d.errs", i), nerr - e0, tbl[i].e);
      if (tbl[i].s) chk($sformatf("tbl%0d.latency", i), strobe_cyc - rise_cyc, SS + 1);
    end

    // Reset in the middle of a frame, then finish it without a new ncs fall
    s0 = nstrobe; e0 = nerr;
    ncs = 1'b0; wait_cyc(4);
    send_bits(32'h2033, 15, 8, 4);
    rst = 1'b1; model_reset();
    wait_cyc(2);
    rst = 1'b0;
    send_bits(32'h2033, 7, 0, 4);
    spck = 1'b0; wait_cyc(4);
    ncs = 1'b1;
    wait_cyc(10);
    check_regs("midrst", s0, e0, 0, 0);
    s0 = nstrobe; e0 = nerr;
    run_frame(32'h2033, 16, 4);
    model_frame(32'h2033, 16, es, ee);
    chk("midrst.next_div", divisor, 8'h33);
    check_regs("midrst.next", s0, e0, es, ee);

    // Randomised frames against the model
    for (int k = 0; k < 40; k++) begin
      logic [31:0] w;
      int nb, ph, r;
      w = $urandom;
      w[15:12] = 4'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) w[7:0] = 8'h01;
      r  = $urandom_range(0, 9);
      nb = (r < 6) ? 16 : (r == 6) ? 15 : (r == 7) ? 17 : (r == 8) ? 14 : 0;
      ph = $urandom_range(SS + 1, 6);
      if ($urandom_range(0, 2) == 0) begin
        // spck activity while deselected must be ignored
        spck = 1'b1; wait_cyc(ph); spck = 1'b0; wait_cyc(ph);
      end
      s0 = nstrobe; e0 = nerr;
      run_frame(w, nb, ph);
      model_frame(w, nb, es, ee);
      check_regs($sformatf("rnd%0d", k), s0, e0, es, ee);
    end

    chk("strobe_err_exclusive", both_seen, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
